// File: rtl/css_mcu_sram_arb.sv
// Round-robin arbiter for a single-port MCU SRAM with bounded burst hold and fixed-latency read return.
// Optional build macro CSS_SRAM_ARB_PRIO_EN gives requester 0 strict priority over round-robin/hold.
module css_mcu_sram_arb #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 39,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                        cptra_ss_clk_i,
    input  logic                        cptra_ss_rst_b_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        sram_cs_o,
    output logic                        sram_we_o,
    output logic [ADDR_W-1:0]           sram_addr_o,
    output logic [DATA_W-1:0]           sram_wdata_o,
    input  logic [DATA_W-1:0]           sram_rdata_i,
    output logic                        busy_o
);

    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = 4;
    localparam logic [CNTW-1:0] MAX_B   = CNTW'(MAX_BURST);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]              r_rr_ptr;
    logic                        r_own_vld;
    logic [IDW-1:0]              r_owner;
    logic [CNTW-1:0]             r_burst_cnt;
    logic [RD_LAT-1:0]           r_pipe_vld;
    logic [RD_LAT-1:0][IDW-1:0]  r_pipe_id;

    logic [NUM_REQ-1:0]          w_req_vld;
    logic                        w_hold;
    logic                        w_arb_vld;
    logic [IDW-1:0]              w_arb_id;
    logic                        w_gnt_vld;
    logic [IDW-1:0]              w_gnt_id;
    logic                        w_gnt_we;
    logic                        w_prio_gnt;
    logic                        w_upd;
    logic [IDW-1:0]              w_rr_nxt;
    logic                        w_out_vld;
    logic [IDW-1:0]              w_out_id;

    // Requests are masked during reset so every combinational output reads 0.
    assign w_req_vld = cptra_ss_rst_b_i ? req_valid_i : '0;

    assign w_hold = r_own_vld && w_req_vld[r_owner] && (r_burst_cnt < MAX_B);

    always_comb begin
        int idx;
        idx       = 0;
        w_arb_vld = 1'b0;
        w_arb_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_arb_vld && w_req_vld[idx]) begin
                w_arb_vld = 1'b1;
                w_arb_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_id   = '0;
        w_prio_gnt = 1'b0;
        if (w_hold) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = r_owner;
        end else if (w_arb_vld) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_arb_id;
        end
`ifdef CSS_SRAM_ARB_PRIO_EN
        // Requester 0 pre-empts without disturbing the owner's burst context.
        if (w_req_vld[0]) begin
            w_gnt_vld  = 1'b1;
            w_gnt_id   = '0;
            w_prio_gnt = 1'b1;
        end
`endif
    end

    assign w_upd    = w_gnt_vld && !w_prio_gnt;
    assign w_gnt_we = w_gnt_vld && req_we_i[w_gnt_id];
    assign w_rr_nxt = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (w_gnt_vld) begin
            req_ready_o[w_gnt_id] = 1'b1;
        end
    end

    assign sram_cs_o    = w_gnt_vld;
    assign sram_we_o    = w_gnt_we;
    assign sram_addr_o  = w_gnt_vld ? req_addr_i[w_gnt_id*ADDR_W +: ADDR_W]  : '0;
    assign sram_wdata_o = w_gnt_vld ? req_wdata_i[w_gnt_id*DATA_W +: DATA_W] : '0;

    always_ff @(posedge cptra_ss_clk_i or negedge cptra_ss_rst_b_i) begin
        if (!cptra_ss_rst_b_i) begin
            r_rr_ptr    <= '0;
            r_own_vld   <= 1'b0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else if (w_upd) begin
            if (r_own_vld && (w_gnt_id == r_owner)) begin
                if (r_burst_cnt < MAX_B) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else begin
                r_own_vld   <= 1'b1;
                r_owner     <= w_gnt_id;
                r_burst_cnt <= CNTW'(1);
            end
            r_rr_ptr <= w_rr_nxt;
        end else if (r_own_vld && !w_req_vld[r_owner]) begin
            r_own_vld   <= 1'b0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end
    end

    always_ff @(posedge cptra_ss_clk_i or negedge cptra_ss_rst_b_i) begin
        if (!cptra_ss_rst_b_i) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= w_gnt_vld && !w_gnt_we;
            r_pipe_id[0]  <= w_gnt_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    assign w_out_vld = r_pipe_vld[RD_LAT-1];
    assign w_out_id  = r_pipe_id[RD_LAT-1];

    always_comb begin
        rsp_valid_o = '0;
        if (w_out_vld) begin
            rsp_valid_o[w_out_id] = 1'b1;
        end
    end

    assign rsp_rdata_o = w_out_vld ? sram_rdata_i : '0;
    assign busy_o      = cptra_ss_rst_b_i && ((|req_valid_i) || (|r_pipe_vld));

endmodule

// File: tb/tb_css_mcu_sram_arb.sv
// Directed bench for css_mcu_sram_arb in the default build (NUM_REQ=3, RD_LAT=1, MAX_BURST=4).
module tb_css_mcu_sram_arb;

    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 39;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              sram_cs;
    logic              sram_we;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [DW-1:0]     sram_rdata;
    logic              busy;

    always #5 clk = ~clk;

    css_mcu_sram_arb #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(4)
    ) dut (
        .cptra_ss_clk_i   (clk),
        .cptra_ss_rst_b_i (rst_b),
        .req_valid_i      (req_valid),
        .req_we_i         (req_we),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_ready_o      (req_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata),
        .sram_cs_o        (sram_cs),
        .sram_we_o        (sram_we),
        .sram_addr_o      (sram_addr),
        .sram_wdata_o     (sram_wdata),
        .sram_rdata_i     (sram_rdata),
        .busy_o           (busy)
    );

    typedef struct {
        logic [NR-1:0] vld;
        logic [NR-1:0] we;
        logic [DW-1:0] rdata;
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rsp;
        logic [DW-1:0] exp_rdata;
        logic          exp_busy;
    } vec_t;

    vec_t          tbl[$];
    logic [AW-1:0] addr_c [NR];
    logic [DW-1:0] wd_c   [NR];
    int            n_chk  = 0;
    int            n_pass = 0;

    localparam logic [DW-1:0] R0 = 39'h5A_0000_00A0;
    localparam logic [DW-1:0] R2 = 39'h3C_0000_00C2;
    localparam logic [DW-1:0] RS = 39'h12_3456_789A;

    function automatic vec_t mk(logic [NR-1:0] vld, logic [NR-1:0] we, logic [DW-1:0] rd,
                                logic [NR-1:0] rdy, logic [NR-1:0] rsp, logic [DW-1:0] erd,
                                logic bsy);
        vec_t v;
        v.vld = vld; v.we = we; v.rdata = rd;
        v.exp_rdy = rdy; v.exp_rsp = rsp; v.exp_rdata = erd; v.exp_busy = bsy;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic check_vec(int k, vec_t v);
        int            gid;
        logic          e_cs;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        gid = 0;
        for (int i = 0; i < NR; i++) if (v.exp_rdy[i]) gid = i;
        e_cs   = |v.exp_rdy;
        e_we   = e_cs && v.we[gid];
        e_addr = e_cs ? addr_c[gid] : '0;
        e_wd   = e_cs ? wd_c[gid]   : '0;
        chk($sformatf("v%0d ready", k), 64'(req_ready), 64'(v.exp_rdy));
        chk($sformatf("v%0d cs", k),    64'(sram_cs),   64'(e_cs));
        chk($sformatf("v%0d we", k),    64'(sram_we),   64'(e_we));
        chk($sformatf("v%0d addr", k),  64'(sram_addr), 64'(e_addr));
        chk($sformatf("v%0d wdata", k), 64'(sram_wdata), 64'(e_wd));
        chk($sformatf("v%0d rsp", k),   64'(rsp_valid), 64'(v.exp_rsp));
        if (v.exp_rsp != '0) chk($sformatf("v%0d rdata", k), 64'(rsp_rdata), 64'(v.exp_rdata));
        chk($sformatf("v%0d busy", k),  64'(busy), 64'(v.exp_busy));
    endtask

    initial begin
        logic [NR-1:0] one;
        addr_c[0] = 16'h0030; addr_c[1] = 16'h0040; addr_c[2] = 16'h0050;
        wd_c[0] = 39'h01_1111_1111; wd_c[1] = 39'h02_2222_2222; wd_c[2] = 39'h04_4444_4444;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = addr_c[i];
            req_wdata[i*DW +: DW] = wd_c[i];
        end

        // Fairness from reset: four grants each, rotating 0,1,2 then back to 0.
        one = 3'b001;
        for (int i = 0; i < 12; i++) tbl.push_back(mk(3'b111, 3'b111, '0, one << (i/4), 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b111, 3'b111, '0, 3'b001, 3'b000, '0, 1'b1));
        // Saturation: owner 0 alone past MAX_BURST keeps the grant, then yields to 1.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(3'b001, 3'b001, '0, 3'b001, 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b011, 3'b011, '0, 3'b010, 3'b000, '0, 1'b1));
        // Owner drop: 2 owns with burst 2, drops; 0 and 1 valid -> 0.
        tbl.push_back(mk(3'b100, 3'b100, '0, 3'b100, 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b100, 3'b100, '0, 3'b100, 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b011, 3'b011, '0, 3'b001, 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b000, 3'b000, '0, 3'b000, 3'b000, '0, 1'b0));
        // Mixed traffic: read 0, write 1, read 2 back to back.
        tbl.push_back(mk(3'b001, 3'b000, '0, 3'b001, 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b010, 3'b010, R0, 3'b010, 3'b001, R0, 1'b1));
        tbl.push_back(mk(3'b100, 3'b000, '0, 3'b100, 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b000, 3'b000, R2, 3'b000, 3'b100, R2, 1'b1));
        tbl.push_back(mk(3'b000, 3'b000, '0, 3'b000, 3'b000, '0, 1'b0));
        // Single read by requester 1 at 0x0040.
        tbl.push_back(mk(3'b010, 3'b000, '0, 3'b010, 3'b000, '0, 1'b1));
        tbl.push_back(mk(3'b000, 3'b000, RS, 3'b000, 3'b010, RS, 1'b1));
        tbl.push_back(mk(3'b000, 3'b000, '0, 3'b000, 3'b000, '0, 1'b0));

        // Reset: every output 0 even with all requesters valid.
        rst_b = 1'b0; req_valid = 3'b111; req_we = 3'b000; sram_rdata = RS;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 64'(req_ready), 64'd0);
        chk("rst cs",    64'(sram_cs),   64'd0);
        chk("rst we",    64'(sram_we),   64'd0);
        chk("rst addr",  64'(sram_addr), 64'd0);
        chk("rst wdata", 64'(sram_wdata), 64'd0);
        chk("rst rsp",   64'(rsp_valid), 64'd0);
        chk("rst rdata", 64'(rsp_rdata), 64'd0);
        chk("rst busy",  64'(busy),      64'd0);
        req_valid = '0; sram_rdata = '0;
        rst_b = 1'b1;

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            req_valid  = tbl[k].vld;
            req_we     = tbl[k].we;
            sram_rdata = tbl[k].rdata;
            @(negedge clk);
            check_vec(k, tbl[k]);
        end

        // Reset mid-op: read by 0 accepted (rr_ptr moves to 1), reset before the response.
        @(posedge clk); #1;
        req_valid = 3'b001; req_we = 3'b000; sram_rdata = R0;
        @(negedge clk);
        chk("midrst accept", 64'(req_ready), 64'(3'b001));
        @(posedge clk); #1;
        req_valid = 3'b000;
        rst_b = 1'b0;
        @(negedge clk);
        chk("midrst rsp", 64'(rsp_valid), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        req_valid = 3'b101; req_we = 3'b111;
        @(negedge clk);
        chk("postrst rsp", 64'(rsp_valid), 64'd0);
        chk("postrst grant", 64'(req_ready), 64'(3'b001));
        chk("postrst addr", 64'(sram_addr), 64'(addr_c[0]));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
